pattern_sequencer: RTL
======================

# pattern_sequencer

Parametrised stimulus/pattern playback engine with a built-in free-running toggle generator. Holds a DEPTH-by-WIDTH pattern memory, cleared word-by-word after reset, loadable through a write port, then plays out a programmable number of patterns with a programmable hold time each. It also produces a divided square wave from a programmable half period. It sits between a bench or control CPU and the block under stimulus, and replaces hand-written per-test pattern sequences with a reusable synthesizable block.

## Interface
- WIDTH, 6, pattern width in bits
- DEPTH, 16, number of pattern words (≥2)
- HOLD_W, 8, width of hold-time field
- HALF_W, 8, width of half-period field
- AW, $clog2(DEPTH), address width (derived)
- CW, $clog2(DEPTH+1), pattern-count width (derived)

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  pattern-memory write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- num_pat  in  CW  patterns per run; sampled at start
- hold  in  HOLD_W  cycles each pattern is held; sampled at start
- start  in  1  begin playback (single-cycle pulse or level)
- stop  in  1  abort playback
- half_period  in  HALF_W  toggle half period in cycles; sampled live
- pat_out  out  WIDTH  current pattern
- pat_valid  out  1  pat_out carries a played pattern
- toggle_out  out  1  divided square wave
- init_done  out  1  memory clear complete
- busy  out  1  INIT or PLAY
- done  out  1  one-cycle pulse at natural end of run

## Operation
- States: INIT, IDLE, PLAY.
- rst: state=INIT, index=0. pat_out=0, pat_valid=0, toggle_out=0, init_done=0, busy=1 (INIT), done=0.
- INIT: each cycle writes mem[index]=0 and increments index. After index DEPTH-1 is written, go to IDLE and set init_done=1. wr_en is ignored during INIT.
- IDLE: wr_en writes mem[wr_addr]. If start=1 and num_pat≠0, latch count=min(num_pat,DEPTH) and hold_eff=max(hold,1), then go to PLAY with addr=0. If start=1 and num_pat=0, stay in IDLE; no done pulse.
- PLAY:
  - On entry to each pattern, register pat_out=mem[addr] and set pat_valid=1.
  - Hold the pattern for hold_eff cycles, then advance addr.
  - After the last pattern, go to IDLE, pulse done for one cycle, and set pat_out=0, pat_valid=0.
- Writes during PLAY are accepted. A write to the address currently shown does not alter pat_out until that address is next loaded.
- stop in PLAY: next cycle state=IDLE, pat_out=0, pat_valid=0, no done. stop has priority over pattern advance.
- start during PLAY or INIT is ignored.
- Simultaneous wr_en and start in IDLE: the write completes first, and the run sees the new data.
- toggle_out:
  - A counter counts to half_period-1, then toggle_out inverts and the counter clears.
  - half_period=0 forces toggle_out=0 and clears the counter.
  - The generator is independent of state and runs during INIT.
  - When half_period changes, the counter clears.

## Timing
- init_done rises DEPTH cycles after the first clock with rst=0.
- Latency from start sampled high (edge N) to first pattern: pat_out valid after edge N+1.
- Pattern k is visible for exactly hold_eff cycles, so a run lasts count×hold_eff cycles.
- done is high for the cycle following the last pattern's final hold cycle.
- rst mid-PLAY: the next cycle is in INIT, outputs are at reset values, and memory is re-cleared.
- toggle_out period is 2×half_period cycles; the first toggle occurs half_period cycles after reset release.

## Configuration
- PATSEQ_LOOP_EN defined:
  - After the last pattern, addr wraps to 0 and playback continues with no gap; no done pulse.
  - The run ends only on stop or rst.
- Undefined: a single run ends with a done pulse, as described above.

## Test plan
- Reset clear, DEPTH=16: release rst → init_done=1 exactly 16 cycles later. A run with num_pat=16, hold=1 outputs 16 zero words.
- Load and play: write 6'b000000, 011001, 011011, 011000, 001000 at addr 0–4; start with num_pat=5, hold=10 → each pattern visible for exactly 10 cycles in order, done pulses at cycle 51, then pat_out=0.
- Edge parameters:
  - hold=0 → each pattern is held 1 cycle.
  - num_pat=0 → no state change, no done.
  - num_pat=20 → clamps to 16.
- Abort: stop on cycle 25 of the run above → IDLE next cycle, pat_out=0, no done. A subsequent start replays from addr 0.
- Toggle: half_period=1 → toggle_out alternates every cycle. half_period=5 → period 10. Switching to 0 → held low.
- With PATSEQ_LOOP_EN: num_pat=3, hold=2 → sequence p0,p0,p1,p1,p2,p2,p0… with no done. stop ends it.

Source files
------------

// File: rtl/pattern_sequencer.sv
// Purpose: pattern memory loaded through a write port, played back with programmable count/hold; plus a free-running divided square wave.
// Latency: first pattern on pat_out one cycle after the edge that samples start; done one cycle after the last hold cycle.
// Backpressure: none; start is ignored outside IDLE, stop aborts a run, writes are accepted whenever not clearing.
// Optional feature: define PATSEQ_LOOP_EN to replay the programmed patterns continuously until stop or rst.
module pattern_sequencer #(
   parameter int WIDTH  = 6,
   parameter int DEPTH  = 16,
   parameter int HOLD_W = 8,
   parameter int HALF_W = 8,
   parameter int AW     = $clog2(DEPTH),
   parameter int CW     = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic [CW-1:0]     num_pat,
   input  logic [HOLD_W-1:0] hold,
   input  logic              start,
   input  logic              stop,
   input  logic [HALF_W-1:0] half_period,
   output logic [WIDTH-1:0]  pat_out,
   output logic              pat_valid,
   output logic              toggle_out,
   output logic              init_done,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_PLAY = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     index;
   logic [AW-1:0]     addr;
   logic [CW-1:0]     count;
   logic [HOLD_W-1:0] hold_eff;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HALF_W-1:0] tog_cnt;
   logic [HALF_W-1:0] half_prev;

   // FSM decode strobes
   logic start_run;
   logic load_first;
   logic hold_dec;
   logic advance;
   logic wrap;
   logic end_run;
   logic abort;

   logic          last_pat;
   logic [AW-1:0] addr_inc;

   assign last_pat  = (CW'(addr) == (count - CW'(1)));
   assign addr_inc  = addr + AW'(1);
   assign init_done = (state != S_INIT);
   assign busy      = (state != S_IDLE);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_nxt;
   end

   // Next-state and datapath control decode
   always_comb begin
      state_nxt  = state;
      start_run  = 1'b0;
      load_first = 1'b0;
      hold_dec   = 1'b0;
      advance    = 1'b0;
      wrap       = 1'b0;
      end_run    = 1'b0;
      abort      = 1'b0;
      case (state)
         S_INIT: begin
            if (index == AW'(DEPTH - 1)) state_nxt = S_IDLE;
         end
         S_IDLE: begin
            if (start && (num_pat != '0)) begin
               start_run = 1'b1;
               state_nxt = S_PLAY;
            end
         end
         S_PLAY: begin
            // stop outranks every other playback action
            if (stop) begin
               abort     = 1'b1;
               state_nxt = S_IDLE;
            end else if (!pat_valid) begin
               load_first = 1'b1;
            end else if (hold_cnt != '0) begin
               hold_dec = 1'b1;
            end else if (!last_pat) begin
               advance = 1'b1;
            end else begin
`ifdef PATSEQ_LOOP_EN
               wrap = 1'b1;
`else
               end_run   = 1'b1;
               state_nxt = S_IDLE;
`endif
            end
         end
         default: state_nxt = S_INIT;
      endcase
   end

   // Pattern memory: cleared one word per cycle in INIT, otherwise written from the port
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == S_INIT) mem[index] <= '0;
         else if (wr_en)      mem[wr_addr] <= wr_data;
      end
   end

   // Playback datapath: clear index, run parameters, current address and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         index     <= '0;
         addr      <= '0;
         count     <= '0;
         hold_eff  <= '0;
         hold_cnt  <= '0;
         pat_out   <= '0;
         pat_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= end_run;
         if (state == S_INIT) begin
            index <= (index == AW'(DEPTH - 1)) ? '0 : index + AW'(1);
         end
         if (start_run) begin
            count    <= (num_pat > CW'(DEPTH)) ? CW'(DEPTH) : num_pat;
            hold_eff <= (hold == '0) ? HOLD_W'(1) : hold;
            addr     <= '0;
         end
         if (load_first) begin
            pat_out   <= mem[addr];
            pat_valid <= 1'b1;
            hold_cnt  <= hold_eff - HOLD_W'(1);
         end
         if (hold_dec) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
         end
         if (advance) begin
            addr     <= addr_inc;
            pat_out  <= mem[addr_inc];
            hold_cnt <= hold_eff - HOLD_W'(1);
         end
         if (wrap) begin
            addr     <= '0;
            pat_out  <= mem[0];
            hold_cnt <= hold_eff - HOLD_W'(1);
         end
         if (end_run || abort) begin
            pat_out   <= '0;
            pat_valid <= 1'b0;
         end
      end
   end

   // Square-wave divider; restarts its count whenever the half period changes
   always_ff @(posedge clk) begin
      if (rst) begin
         tog_cnt    <= '0;
         toggle_out <= 1'b0;
         half_prev  <= half_period;
      end else begin
         half_prev <= half_period;
         if (half_period == '0) begin
            tog_cnt    <= '0;
            toggle_out <= 1'b0;
         end else if (half_period != half_prev) begin
            tog_cnt <= '0;
         end else if (tog_cnt == (half_period - HALF_W'(1))) begin
            tog_cnt    <= '0;
            toggle_out <= ~toggle_out;
         end else begin
            tog_cnt <= tog_cnt + HALF_W'(1);
         end
      end
   end

endmodule
